// File: rtl/reg_write_arbiter.sv
// Register-file write arbiter: CPU writeback vs. debug/host writes with starvation forcing.
// Optional power-up clear of r0..r31 is built in when REGARB_CLEAR_EN is defined.
module reg_write_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int DW           = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_we,
  input  logic [4:0]    cpu_wr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  input  logic          dbg_valid,
  output logic          dbg_ready,
  input  logic [4:0]    dbg_wr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          RegWrite,
  output logic [4:0]    WR,
  output logic [DW-1:0] WData,
  output logic          busy
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic          run_s;
  logic          clr_s;
  logic [4:0]    clr_idx_s;
  logic [3:0]    starve_r;
  logic          force_s;
  logic          cpu_gnt_s;
  logic          dbg_hs_s;
  logic          wr_en_s;
  logic [4:0]    wr_idx_s;
  logic [DW-1:0] wr_data_s;

`ifdef REGARB_CLEAR_EN
  typedef enum logic [0:0] {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t     state_r;
  state_t     state_nxt_s;
  logic [4:0] clr_idx_r;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= CLEAR;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: leave CLEAR once index 31 has been issued
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      CLEAR: begin
        if (clr_idx_r == 5'd31) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = CLEAR;
        end
      end
      RUN:     state_nxt_s = RUN;
      default: state_nxt_s = CLEAR;
    endcase
  end

  // Clear index walks 0..31 while clearing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_idx_r <= 5'd0;
    end else if (state_r == CLEAR) begin
      clr_idx_r <= clr_idx_r + 5'd1;
    end else begin
      clr_idx_r <= clr_idx_r;
    end
  end

  assign run_s     = (state_r == RUN);
  assign clr_s     = (state_r == CLEAR);
  assign clr_idx_s = clr_idx_r;
`else
  assign run_s     = 1'b1;
  assign clr_s     = 1'b0;
  assign clr_idx_s = 5'd0;
`endif

  assign force_s   = (starve_r == LIMIT);
  assign dbg_ready = run_s & (~cpu_we | force_s);
  assign cpu_stall = clr_s | force_s;
  assign busy      = clr_s;
  assign cpu_gnt_s = run_s & cpu_we & ~force_s;
  assign dbg_hs_s  = dbg_valid & dbg_ready;

  // Starvation counter: counts blocked debug cycles, saturates at the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_r <= 4'd0;
    end else if (dbg_valid & ~dbg_ready) begin
      if (starve_r != LIMIT) begin
        starve_r <= starve_r + 4'd1;
      end else begin
        starve_r <= starve_r;
      end
    end else begin
      starve_r <= 4'd0;
    end
  end

  // Write select; r0 writes handshake but leave the port untouched (WR/WData hold)
  always_comb begin
    wr_en_s   = 1'b0;
    wr_idx_s  = WR;
    wr_data_s = WData;
    if (clr_s) begin
      wr_en_s   = 1'b1;
      wr_idx_s  = clr_idx_s;
      wr_data_s = '0;
    end else if (cpu_gnt_s) begin
      if (cpu_wr != 5'd0) begin
        wr_en_s   = 1'b1;
        wr_idx_s  = cpu_wr;
        wr_data_s = cpu_wdata;
      end else begin
        wr_en_s   = 1'b0;
      end
    end else if (dbg_hs_s) begin
      if (dbg_wr != 5'd0) begin
        wr_en_s   = 1'b1;
        wr_idx_s  = dbg_wr;
        wr_data_s = dbg_wdata;
      end else begin
        wr_en_s   = 1'b0;
      end
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Registered register-file write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWrite <= 1'b0;
      WR       <= 5'd0;
      WData    <= '0;
    end else begin
      RegWrite <= wr_en_s;
      WR       <= wr_idx_s;
      WData    <= wr_data_s;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Randomized self-checking bench for reg_write_arbiter against a cycle-level reference model.
// Clear-sequence checks are compiled in only when REGARB_CLEAR_EN is defined.
module tb_reg_write_arbiter;

  localparam int SL = 4;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          cpu_we;
  logic [4:0]    cpu_wr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall;
  logic          dbg_valid;
  logic          dbg_ready;
  logic [4:0]    dbg_wr;
  logic [DW-1:0] dbg_wdata;
  logic          RegWrite;
  logic [4:0]    WR;
  logic [DW-1:0] WData;
  logic          busy;

  int total = 0;
  int bad   = 0;

  // reference model state
  int          m_starve;
  logic        m_we;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;

  reg_write_arbiter #(.STARVE_LIMIT(SL), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .cpu_we(cpu_we), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_wr(dbg_wr), .dbg_wdata(dbg_wdata),
    .RegWrite(RegWrite), .WR(WR), .WData(WData), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_write(input logic [4:0] idx, input logic [31:0] data);
    if (idx != 5'd0) begin
      m_we = 1'b1;
      m_wr = idx;
      m_wd = data;
    end else begin
      m_we = 1'b0;
    end
  endtask

  // one RUN cycle: drive at negedge, check combinational outputs, then the registered port
  task automatic step(input logic we, input logic [4:0] cwr, input logic [31:0] cwd,
                      input logic dv, input logic [4:0] dwr, input logic [31:0] dwd);
    logic frc;
    logic rdy;
    cpu_we = we; cpu_wr = cwr; cpu_wdata = cwd;
    dbg_valid = dv; dbg_wr = dwr; dbg_wdata = dwd;
    #1;
    frc = (m_starve == SL);
    rdy = !we || frc;
    check_eq("dbg_ready", {31'd0, dbg_ready}, {31'd0, rdy});
    check_eq("cpu_stall", {31'd0, cpu_stall}, {31'd0, frc});
    check_eq("busy_run", {31'd0, busy}, 32'd0);
    m_we = 1'b0;
    if (frc) begin
      if (dv) model_write(dwr, dwd);
    end else if (we) begin
      model_write(cwr, cwd);
    end else if (dv) begin
      model_write(dwr, dwd);
    end
    if (dv && !rdy) m_starve = (m_starve < SL) ? m_starve + 1 : SL;
    else            m_starve = 0;
    @(posedge clk);
    #1;
    check_eq("RegWrite", {31'd0, RegWrite}, {31'd0, m_we});
    check_eq("WR", {27'd0, WR}, {27'd0, m_wr});
    check_eq("WData", WData, m_wd);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    cpu_we = 1'b0; cpu_wr = 5'd0; cpu_wdata = 32'd0;
    dbg_valid = 1'b0; dbg_wr = 5'd0; dbg_wdata = 32'd0;
  endtask

  // asynchronous reset pulse between clock edges; outputs must clear immediately
  task automatic pulse_reset();
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_RegWrite", {31'd0, RegWrite}, 32'd0);
    check_eq("rst_WR", {27'd0, WR}, 32'd0);
    check_eq("rst_WData", WData, 32'd0);
`ifdef REGARB_CLEAR_EN
    check_eq("rst_busy", {31'd0, busy}, 32'd1);
`else
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
`endif
    idle_inputs();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_starve = 0; m_we = 1'b0; m_wr = 5'd0; m_wd = 32'd0;
  endtask

`ifdef REGARB_CLEAR_EN
  task automatic run_clear(input int n);
    for (int k = 0; k < n; k++) begin
      idle_inputs();
      #1;
      check_eq("clr_stall", {31'd0, cpu_stall}, 32'd1);
      check_eq("clr_ready", {31'd0, dbg_ready}, 32'd0);
      check_eq("clr_busy", {31'd0, busy}, 32'd1);
      @(posedge clk);
      #1;
      check_eq("clr_RegWrite", {31'd0, RegWrite}, 32'd1);
      check_eq("clr_WR", {27'd0, WR}, k);
      check_eq("clr_WData", WData, 32'd0);
      check_eq("clr_busy_after", {31'd0, busy}, (k == 31) ? 32'd0 : 32'd1);
      @(negedge clk);
    end
    m_we = 1'b1; m_wr = 5'd31; m_wd = 32'd0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    idle_inputs();
    m_starve = 0; m_we = 1'b0; m_wr = 5'd0; m_wd = 32'd0;
    @(negedge clk);
    pulse_reset();

`ifdef REGARB_CLEAR_EN
    run_clear(11);
    pulse_reset();
    run_clear(32);
`else
    // first cycle after release: debug accepted immediately
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'd9);
`endif

    // CPU writeback
    step(1'b1, 5'd3, 32'd5, 1'b0, 5'd0, 32'd0);
    // CPU to r0 and debug to r0
    step(1'b1, 5'd0, 32'h5, 1'b0, 5'd0, 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h77);
    // starvation: 4 blocked cycles then forced debug grant
    for (int i = 0; i < SL + 1; i++) step(1'b1, 5'd1 + 5'(i), 32'h100 + i, 1'b1, 5'd7, 32'hA5);
    // same index from both sources: CPU wins, debug stays pending
    step(1'b1, 5'd9, 32'h11, 1'b1, 5'd9, 32'h22);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h22);
    // debug drops before handshake: nothing written
    step(1'b1, 5'd4, 32'h44, 1'b1, 5'd5, 32'h55);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 32'h55);

    // build starvation then reset: pending debug must be forgotten
    for (int i = 0; i < 3; i++) step(1'b1, 5'd6, 32'h66, 1'b1, 5'd8, 32'h88);
    pulse_reset();
`ifdef REGARB_CLEAR_EN
    run_clear(32);
`endif
    step(1'b1, 5'd10, 32'hAA, 1'b1, 5'd8, 32'h88);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom,
           ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive blocked debug cycles before a forced debug grant (range 1..15).
REQ-002 The block SHALL have parameter DW, default 32, meaning register data width.
REQ-003 The block SHALL use a single clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 cpu_we  in  1  CPU writeback request, single-cycle, no handshake.
REQ-006 cpu_wr  in  5  CPU writeback register index.
REQ-007 cpu_wdata  in  DW  CPU writeback data.
REQ-008 cpu_stall  out  1  CPU SHALL hold its writeback while high.
REQ-009 dbg_valid  in  1  debug/host write request valid.
REQ-010 dbg_ready  out  1  debug write accepted this cycle (handshake = valid & ready).
REQ-011 dbg_wr  in  5  debug register index.
REQ-012 dbg_wdata  in  DW  debug write data.
REQ-013 RegWrite  out  1  register-file write enable (registered).
REQ-014 WR  out  5  register-file write index (registered).
REQ-015 WData  out  DW  register-file write data (registered).
REQ-016 busy  out  1  clear sequence in progress.

Function
REQ-017 States SHALL be CLEAR and RUN; CLEAR -> RUN after the write of index 31 is issued; RUN is left only by reset.
REQ-018 In CLEAR, rising edge k (k=1..32) after reset deassertion SHALL present RegWrite=1, WR=k-1, WData=0; busy=1 until edge 32, 0 from edge 32.
REQ-019 In CLEAR, cpu_stall SHALL be 1 and dbg_ready SHALL be 0.
REQ-020 In RUN, a granted request SHALL appear on RegWrite/WR/WData after exactly one clock edge; with no grant, RegWrite=0 and WR/WData hold.
REQ-021 In RUN without force, cpu_we=1 SHALL win; dbg_ready = RUN & (!cpu_we | force), combinational.
REQ-022 A starvation counter SHALL increment each cycle dbg_valid=1 and dbg_ready=0, clear on a debug handshake or dbg_valid=0, and saturate at STARVE_LIMIT.
REQ-023 force = (counter == STARVE_LIMIT); in a force cycle, cpu_stall=1, cpu_we SHALL be ignored, and the debug request SHALL be granted.
REQ-024 cpu_stall SHALL be 0 in RUN except in force cycles.
REQ-025 In RUN, a granted write with index 0 (either source) SHALL complete its handshake but produce RegWrite=0 (r0 hardwired zero).
REQ-026 Simultaneous CPU and debug requests to the same index SHALL grant CPU only; debug stays pending with data unchanged.
REQ-027 A debug write SHALL be accepted at most once per handshake; dbg_valid dropping before handshake SHALL discard the request without any write.

Reset
REQ-028 rst=1 SHALL immediately force RegWrite=0, WR=0, WData=0, counter=0, state=CLEAR (macro defined) or RUN (undefined), busy=1 or 0 accordingly.
REQ-029 Reset asserted mid-CLEAR SHALL restart the clear at index 0 after release.
REQ-030 Reset asserted in RUN SHALL drop any pending, unacknowledged debug request.

Configuration
REQ-031 Macro REGARB_CLEAR_EN defined: CLEAR state and clear sequence SHALL be built in per REQ-017..019.
REQ-032 Macro REGARB_CLEAR_EN undefined: no CLEAR logic; block SHALL enter RUN at reset release, busy tied 0, first grant possible on the first edge.

Verification
REQ-033 Reset release, REGARB_CLEAR_EN defined -> 32 consecutive writes WR=0..31, WData=0; busy falls at edge 32; cpu_stall=1 throughout.
REQ-034 RUN, cpu_we=1 cpu_wr=3 cpu_wdata=5 -> next edge RegWrite=1 WR=3 WData=5; cpu_stall=0.
REQ-035 RUN, cpu_we=1 every cycle, dbg_valid=1 dbg_wr=7 dbg_wdata=0xA5 -> dbg_ready=0 for 4 cycles, 5th cycle force: cpu_stall=1, dbg_ready=1, next edge WR=7 WData=0xA5.
REQ-036 RUN, cpu_we=1 cpu_wr=0 WData=0x5 -> RegWrite stays 0; debug write to index 0 handshakes with RegWrite=0.
REQ-037 rst pulsed at clear index 10 -> outputs zero immediately; after release clear restarts at WR=0 and runs 32 writes.
REQ-038 REGARB_CLEAR_EN undefined, dbg_valid=1 dbg_wr=2 dbg_wdata=9 at reset release -> busy=0, dbg_ready=1 in the first cycle, RegWrite=1 WR=2 WData=9 after the first edge.
